// File: rtl/t9990_vram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// t9990_vram_arbiter_pkg
// Shared VRAM requester identifiers for the tiny9990 VDP.
//   vram_req_t   : requester index (also the bit position in grant/ACK vectors)
//   VRAM_REQ_NUM : number of VRAM requesters
// ----------------------------------------------------------------------------
package t9990_vram_arbiter_pkg;

   typedef enum logic [1:0] {
      REQ_DISP = 2'd0,
      REQ_CPU  = 2'd1,
      REQ_CMD  = 2'd2
   } vram_req_t;

   localparam int unsigned VRAM_REQ_NUM = 3;

endpackage

// File: rtl/t9990_vram_arbiter_slot_pick.sv
// ----------------------------------------------------------------------------
// t9990_vram_slot_pick
// Purely combinational slot winner selection.
// Ports:
//   i_elig      eligible requesters, indexed by vram_req_t
//   i_disp_run  consecutive display grants made while another was pending
//   i_rr_last   CPU or CMD, whichever of the two was granted most recently
//   o_grant     one-hot winner (all zero when nothing is eligible)
// ----------------------------------------------------------------------------
module t9990_vram_slot_pick
   import t9990_vram_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic [VRAM_REQ_NUM-1:0] i_elig,
   input  logic [1:0]              i_disp_run,
   input  logic [1:0]              i_rr_last,
   output logic [VRAM_REQ_NUM-1:0] o_grant
);

   logic                    w_other;
   logic                    w_disp_blocked;
   logic [VRAM_REQ_NUM-1:0] w_grant;

   assign w_other        = i_elig[REQ_CPU] | i_elig[REQ_CMD];
   // Display yields one slot once it has hogged STARVE_LIMIT slots in a row.
   assign w_disp_blocked = (i_disp_run == 2'(STARVE_LIMIT)) && w_other;

   always_comb begin
      w_grant = '0;
      if (i_elig[REQ_DISP] && !w_disp_blocked) begin
         w_grant[REQ_DISP] = 1'b1;
      end else if (i_elig[REQ_CPU] && i_elig[REQ_CMD]) begin
         if (i_rr_last == REQ_CMD) begin
            w_grant[REQ_CPU] = 1'b1;
         end else begin
            w_grant[REQ_CMD] = 1'b1;
         end
      end else if (i_elig[REQ_CPU]) begin
         w_grant[REQ_CPU] = 1'b1;
      end else if (i_elig[REQ_CMD]) begin
         w_grant[REQ_CMD] = 1'b1;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/t9990_vram_arbiter.sv
// ----------------------------------------------------------------------------
// t9990_vram_arbiter
// Grants each VRAM slot (MEM_REQ strobe) to one of display, CPU or command
// engine, runs the RAM access and returns an ACK pulse plus read data.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_tg_en, i_mem_req          timing enable and one-cycle slot strobe
//   i_{disp,cpu,cmd}_req/_addr  requests held until ACK, with addresses
//   i_{cpu,cmd}_we/_wdata       write qualifiers (display is read-only)
//   o_{disp,cpu,cmd}_ack        one-cycle completion pulses
//   o_rdata                     registered read data, valid with the ACK
//   o_ram_ce/_we/_addr/_wdata   RAM strobe and access, held until next issue
//   i_ram_rdata                 RAM read data
// RAM_RDATA is sampled on the edge that enters DONE, i.e. RD_LAT-1 cycles
// after the RAM_CE cycle, so ACK and RDATA appear RD_LAT cycles after RAM_CE.
// ----------------------------------------------------------------------------
module t9990_vram_arbiter
   import t9990_vram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 19,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned RD_LAT       = 2,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tg_en,
   input  logic              i_mem_req,
   input  logic              i_disp_req,
   input  logic              i_cpu_req,
   input  logic              i_cmd_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic              i_cpu_we,
   input  logic              i_cmd_we,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   output logic              o_disp_ack,
   output logic              o_cpu_ack,
   output logic              o_cmd_ack,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_ram_ce,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   // Last WAIT-cycle count value; unused when RD_LAT is 1 (ISSUE goes to DONE).
   localparam logic [1:0] WaitLast = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   state_e                  r_state, w_state_d;
   logic [1:0]              r_wait_cnt, w_wait_cnt_d;
   logic [VRAM_REQ_NUM-1:0] r_owner, w_owner_d;
   logic [VRAM_REQ_NUM-1:0] r_ack, w_ack_d;
   logic [VRAM_REQ_NUM-1:0] r_ack_prev;
   logic [1:0]              r_disp_run, w_disp_run_d;
   vram_req_t               r_rr_last, w_rr_last_d;
   logic                    r_ram_ce, w_ram_ce_d;
   logic                    r_ram_we, w_ram_we_d;
   logic [ADDR_W-1:0]       r_ram_addr, w_ram_addr_d;
   logic [DATA_W-1:0]       r_ram_wdata, w_ram_wdata_d;
   logic [DATA_W-1:0]       r_rdata, w_rdata_d;

   logic [VRAM_REQ_NUM-1:0] w_req;
   logic [VRAM_REQ_NUM-1:0] w_elig;
   logic [VRAM_REQ_NUM-1:0] w_grant;
   logic                    w_other;
   logic                    w_slot_go;

   assign w_req = {i_cmd_req, i_cpu_req, i_disp_req};
   // A REQ still high in the cycle after its ACK is the old request, not a new one.
   assign w_elig    = w_req & ~r_ack_prev;
   assign w_other   = w_elig[REQ_CPU] | w_elig[REQ_CMD];
   assign w_slot_go = (r_state == StIdle) && i_mem_req && i_tg_en && (|w_elig);

   t9990_vram_slot_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_slot_pick (
      .i_elig     (w_elig),
      .i_disp_run (r_disp_run),
      .i_rr_last  (r_rr_last),
      .o_grant    (w_grant)
   );

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next state; slots arriving outside IDLE are simply not looked at
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_slot_go) w_state_d = StIssue;
         StIssue: w_state_d = (RD_LAT == 1) ? StDone : StWait;
         StWait:  if (r_wait_cnt == WaitLast) w_state_d = StDone;
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // FSM outputs and arbitration bookkeeping (next values of registered outputs)
   always_comb begin
      w_wait_cnt_d  = (r_state == StWait) ? (r_wait_cnt + 2'd1) : 2'd0;
      w_owner_d     = r_owner;
      w_ack_d       = '0;
      w_disp_run_d  = r_disp_run;
      w_rr_last_d   = r_rr_last;
      w_ram_ce_d    = 1'b0;
      w_ram_we_d    = r_ram_we;
      w_ram_addr_d  = r_ram_addr;
      w_ram_wdata_d = r_ram_wdata;
      w_rdata_d     = r_rdata;

      if (w_slot_go) begin
         w_owner_d  = w_grant;
         w_ram_ce_d = 1'b1;
         unique case (w_grant)
            3'b001: begin
               w_ram_addr_d  = i_disp_addr;
               w_ram_we_d    = 1'b0;
               w_ram_wdata_d = '0;
               if (!w_other) begin
                  w_disp_run_d = 2'd0;
               end else if (r_disp_run != 2'd3) begin
                  w_disp_run_d = r_disp_run + 2'd1;
               end
            end
            3'b010: begin
               w_ram_addr_d  = i_cpu_addr;
               w_ram_we_d    = i_cpu_we;
               w_ram_wdata_d = i_cpu_wdata;
               w_disp_run_d  = 2'd0;
               w_rr_last_d   = REQ_CPU;
            end
            3'b100: begin
               w_ram_addr_d  = i_cmd_addr;
               w_ram_we_d    = i_cmd_we;
               w_ram_wdata_d = i_cmd_wdata;
               w_disp_run_d  = 2'd0;
               w_rr_last_d   = REQ_CMD;
            end
            default: ;
         endcase
      end

      // Entering DONE: pulse the owner's ACK and capture read data
      if (w_state_d == StDone) begin
         w_ack_d = r_owner;
         if (!r_ram_we) begin
            w_rdata_d = i_ram_rdata;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wait_cnt  <= 2'd0;
         r_owner     <= '0;
         r_ack       <= '0;
         r_ack_prev  <= '0;
         r_disp_run  <= 2'd0;
         r_rr_last   <= REQ_CMD;
         r_ram_ce    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         r_wait_cnt  <= w_wait_cnt_d;
         r_owner     <= w_owner_d;
         r_ack       <= w_ack_d;
         r_ack_prev  <= r_ack;
         r_disp_run  <= w_disp_run_d;
         r_rr_last   <= w_rr_last_d;
         r_ram_ce    <= w_ram_ce_d;
         r_ram_we    <= w_ram_we_d;
         r_ram_addr  <= w_ram_addr_d;
         r_ram_wdata <= w_ram_wdata_d;
         r_rdata     <= w_rdata_d;
      end
   end

   assign o_disp_ack  = r_ack[REQ_DISP];
   assign o_cpu_ack   = r_ack[REQ_CPU];
   assign o_cmd_ack   = r_ack[REQ_CMD];
   assign o_rdata     = r_rdata;
   assign o_ram_ce    = r_ram_ce;
   assign o_ram_we    = r_ram_we;
   assign o_ram_addr  = r_ram_addr;
   assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_t9990_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_t9990_vram_arbiter
// Directed bench for t9990_vram_arbiter with a small RAM model whose read data
// is the latched read address XOR 16'h5A5A.
//   0x12345 -> 0x791F, 0x00200 -> 0x585A, 0x00300 -> 0x595A
// ----------------------------------------------------------------------------
module tb_t9990_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        tg_en;
   logic        mem_req;
   logic        disp_req, cpu_req, cmd_req;
   logic [18:0] disp_addr, cpu_addr, cmd_addr;
   logic        cpu_we, cmd_we;
   logic [15:0] cpu_wdata, cmd_wdata;
   logic        disp_ack, cpu_ack, cmd_ack;
   logic [15:0] rdata;
   logic        ram_ce, ram_we;
   logic [18:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   logic [2:0]  acks;
   logic [18:0] rd_addr = '0;
   int          ce_cnt = 0;
   int          ack_cnt = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   localparam logic [2:0] G_DISP = 3'b001;
   localparam logic [2:0] G_CPU  = 3'b010;
   localparam logic [2:0] G_CMD  = 3'b100;

   always #5 clk = ~clk;

   t9990_vram_arbiter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tg_en     (tg_en),
      .i_mem_req   (mem_req),
      .i_disp_req  (disp_req),
      .i_cpu_req   (cpu_req),
      .i_cmd_req   (cmd_req),
      .i_disp_addr (disp_addr),
      .i_cpu_addr  (cpu_addr),
      .i_cmd_addr  (cmd_addr),
      .i_cpu_we    (cpu_we),
      .i_cmd_we    (cmd_we),
      .i_cpu_wdata (cpu_wdata),
      .i_cmd_wdata (cmd_wdata),
      .o_disp_ack  (disp_ack),
      .o_cpu_ack   (cpu_ack),
      .o_cmd_ack   (cmd_ack),
      .o_rdata     (rdata),
      .o_ram_ce    (ram_ce),
      .o_ram_we    (ram_we),
      .o_ram_addr  (ram_addr),
      .o_ram_wdata (ram_wdata),
      .i_ram_rdata (ram_rdata)
   );

   assign acks = {cmd_ack, cpu_ack, disp_ack};

   // RAM model: read data stays stable from the cycle after RAM_CE onwards
   always @(posedge clk) begin
      if (ram_ce && !ram_we) rd_addr <= ram_addr;
   end
   assign ram_rdata = rd_addr[15:0] ^ 16'h5A5A;

   always @(posedge clk) begin
      if (ram_ce) ce_cnt <= ce_cnt + 1;
      if (|acks)  ack_cnt <= ack_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One slot with period 8: strobe at t, RAM_CE at t+1, ACK at t+3.
   // Called and returns right after a falling edge.
   task automatic run_slot(input string tag, input logic [2:0] exp_gnt,
                           input logic [18:0] exp_addr, input logic exp_we,
                           input logic [15:0] exp_wdata, input logic [15:0] exp_rdata);
      mem_req = 1'b1;
      @(negedge clk);
      mem_req = 1'b0;
      check({tag, ".ce"}, 32'(ram_ce), 32'd1);
      check({tag, ".addr"}, 32'(ram_addr), 32'(exp_addr));
      check({tag, ".we"}, 32'(ram_we), 32'(exp_we));
      if (exp_we) check({tag, ".wdata"}, 32'(ram_wdata), 32'(exp_wdata));
      @(negedge clk);
      check({tag, ".early_ack"}, 32'(acks), 32'd0);
      @(negedge clk);
      check({tag, ".ack"}, 32'(acks), 32'(exp_gnt));
      check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int ce0, ack0;
      rst       = 1'b1;
      tg_en     = 1'b1;
      mem_req   = 1'b0;
      disp_req  = 1'b0;
      cpu_req   = 1'b0;
      cmd_req   = 1'b0;
      disp_addr = 19'h12345;
      cpu_addr  = 19'h00200;
      cmd_addr  = 19'h00300;
      cpu_we    = 1'b0;
      cmd_we    = 1'b0;
      cpu_wdata = 16'h0000;
      cmd_wdata = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst.ce", 32'(ram_ce), 32'd0);
      check("rst.ack", 32'(acks), 32'd0);
      check("rst.rdata", 32'(rdata), 32'd0);
      check("rst.addr", 32'(ram_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Display only
      disp_req = 1'b1;
      run_slot("disp0", G_DISP, 19'h12345, 1'b0, 16'h0, 16'h791F);
      run_slot("disp1", G_DISP, 19'h12345, 1'b0, 16'h0, 16'h791F);
      disp_req = 1'b0;

      // CPU/CMD round robin, CPU wins the first tie after reset
      cpu_req = 1'b1;
      cmd_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) run_slot($sformatf("rr%0d", i), G_CPU, 19'h00200, 1'b0, 16'h0, 16'h585A);
         else            run_slot($sformatf("rr%0d", i), G_CMD, 19'h00300, 1'b0, 16'h0, 16'h595A);
      end
      cmd_req = 1'b0;

      // Anti-starvation: DISP, DISP, DISP, CPU repeating
      disp_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i % 4 == 3) run_slot($sformatf("stv%0d", i), G_CPU, 19'h00200, 1'b0, 16'h0, 16'h585A);
         else            run_slot($sformatf("stv%0d", i), G_DISP, 19'h12345, 1'b0, 16'h0, 16'h791F);
      end
      disp_req = 1'b0;
      cpu_req  = 1'b0;

      // Dropped slots: spacing 3 with RD_LAT 2 -> every second strobe ignored
      cmd_req = 1'b1;
      ce0  = ce_cnt;
      ack0 = ack_cnt;
      for (int i = 0; i < 6; i++) begin
         mem_req = 1'b1;
         @(negedge clk);
         mem_req = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("drop.ce_count", 32'(ce_cnt - ce0), 32'd3);
      check("drop.ack_count", 32'(ack_cnt - ack0), 32'd3);
      check("drop.rdata", 32'(rdata), 32'h595A);

      // TG_EN low: nothing granted even with everyone requesting
      tg_en    = 1'b0;
      disp_req = 1'b1;
      cpu_req  = 1'b1;
      ce0  = ce_cnt;
      ack0 = ack_cnt;
      for (int i = 0; i < 3; i++) begin
         mem_req = 1'b1;
         @(negedge clk);
         mem_req = 1'b0;
         repeat (7) @(negedge clk);
      end
      check("tg_off.ce_count", 32'(ce_cnt - ce0), 32'd0);
      check("tg_off.ack_count", 32'(ack_cnt - ack0), 32'd0);

      // CPU write: RDATA keeps the last read value
      disp_req  = 1'b0;
      cmd_req   = 1'b0;
      cpu_addr  = 19'h00100;
      cpu_we    = 1'b1;
      cpu_wdata = 16'hBEEF;
      tg_en     = 1'b1;
      run_slot("cpu_wr", G_CPU, 19'h00100, 1'b1, 16'hBEEF, 16'h595A);

      // Reset during WAIT of a CPU read (leaves rr_last at CPU before reset)
      cpu_addr = 19'h00200;
      cpu_we   = 1'b0;
      mem_req  = 1'b1;
      @(negedge clk);
      mem_req = 1'b0;
      check("rstmid.ce", 32'(ram_ce), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid.ce0", 32'(ram_ce), 32'd0);
      check("rstmid.we0", 32'(ram_we), 32'd0);
      check("rstmid.addr0", 32'(ram_addr), 32'd0);
      check("rstmid.wdata0", 32'(ram_wdata), 32'd0);
      check("rstmid.rdata0", 32'(rdata), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rstmid.noack%0d", i), 32'(acks), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("rstmid.noack_rel", 32'(acks), 32'd0);
      cmd_req = 1'b1;
      run_slot("post_rst_tie", G_CPU, 19'h00200, 1'b0, 16'h0, 16'h585A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/t9990_vram_arbiter.md
# t9990_vram_arbiter

Schedules every VRAM access slot of the tiny9990 VDP among three requesters: display fetch, CPU port and command engine. It sits between the clock block, which supplies the `MEM_REQ` slot strobe and `TG_EN`, and the RAM interface. It grants at most one access per slot, drives the RAM strobe and returns read data with a per-requester acknowledge. Display has priority, bounded by an anti-starvation counter; CPU and command share the remaining slots round-robin.

## Interface
- `ADDR_W`, 19: VRAM word address width.
- `DATA_W`, 16: VRAM data width.
- `RD_LAT`, 2: cycles from `RAM_CE` to valid `RAM_RDATA`; legal range 1..3.
- `STARVE_LIMIT`, 3: consecutive display grants allowed while another requester is pending.
- `CLK`  in  1  the block's single clock (already decided).
- `RESET`  in  1  reset, asynchronous, active-high (already decided).
- `TG_EN`  in  1  timing generator enable; while 0, slots are ignored.
- `MEM_REQ`  in  1  one-cycle slot strobe.
- `DISP_REQ`, `CPU_REQ`, `CMD_REQ`  in  1 each  access request; held until the matching ACK.
- `DISP_ADDR`, `CPU_ADDR`, `CMD_ADDR`  in  ADDR_W each  access address.
- `CPU_WE`, `CMD_WE`  in  1 each  write enable; display is read-only.
- `CPU_WDATA`, `CMD_WDATA`  in  DATA_W each  write data.
- `DISP_ACK`, `CPU_ACK`, `CMD_ACK`  out  1 each  one-cycle completion pulse.
- `RDATA`  out  DATA_W  registered read data, valid in the ACK cycle.
- `RAM_CE`  out  1  one-cycle access strobe.
- `RAM_WE`  out  1  write qualifier for `RAM_CE`.
- `RAM_ADDR`  out  ADDR_W  access address.
- `RAM_WDATA`  out  DATA_W  write data.
- `RAM_RDATA`  in  DATA_W  read data from RAM.

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE: on `MEM_REQ && TG_EN` with at least one eligible request.
  - ISSUE -> WAIT: after one cycle.
  - WAIT -> DONE: after RD_LAT-1 further cycles.
  - DONE -> IDLE: after one cycle.
- A `MEM_REQ` arriving in any state other than IDLE is dropped. No grant is made and no state changes.
- Eligibility: a requester is eligible if its REQ is high and it did not receive an ACK in the previous cycle. The previous-cycle rule stops a still-high REQ from being taken as a new request.
- Pick order:
  - DISP wins unless `disp_run == STARVE_LIMIT` and CPU or CMD is eligible.
  - Among CPU and CMD, `rr_last` decides: the one not granted most recently wins; a single eligible requester wins outright.
- `disp_run` (2-bit saturating):
  - +1 on a DISP grant while CPU or CMD is eligible.
  - Cleared on any CPU or CMD grant, and on a DISP grant with no competitor.
- `rr_last` updates only on CPU or CMD grants.
- In ISSUE, the owner's ADDR, WE and WDATA are latched onto the RAM_* outputs and `RAM_CE` is pulsed.
- In DONE:
  - The owner's ACK is pulsed.
  - For a read, `RDATA` is updated from `RAM_RDATA` sampled in that cycle.
  - For a write, `RDATA` is held.
- `TG_EN` low: no new grant. An access already in flight completes normally. `rr_last` and `disp_run` hold their values.
- Reset (asynchronous, any state):
  - FSM to IDLE.
  - All ACKs, `RAM_CE` and `RAM_WE` to 0.
  - `RAM_ADDR`, `RAM_WDATA` and `RDATA` to 0.
  - `disp_run` to 0; `rr_last` to CMD, so CPU wins the first tie.
  - An in-flight access is abandoned with no ACK.

## Timing
- `MEM_REQ` at cycle t -> `RAM_CE` high in cycle t+1 -> ACK and `RDATA` valid in cycle t+1+RD_LAT.
- Arbitration uses REQ values sampled at cycle t. A REQ that rises in cycle t+1 waits for the next slot.
- The slot period must be at least RD_LAT+3 cycles for every slot to be usable. Shorter spacing is legal; the excess slots are dropped.
- The RAM_* outputs hold their values until the next ISSUE.
- The outputs are registered, with no combinational path from REQ to the outputs.

## Structure
- The `T9990` package gains `vram_req_t` (REQ_DISP=0, REQ_CPU=1, REQ_CMD=2) and `VRAM_REQ_NUM=3`.
- The FSM state enum stays local to the module.
- Sub-module `t9990_vram_slot_pick` is purely combinational. It takes the eligible vector, `disp_run` and `rr_last`, and returns a one-hot grant.

## Test plan
- **Display only:** DISP_REQ=1, ADDR=0x12345, MEM_REQ every 8 cycles.
  - Expect `RAM_CE` at t+1 with `RAM_ADDR`=0x12345 and `RAM_WE`=0.
  - Expect `DISP_ACK` at t+3 with `RDATA` equal to the RAM model value.
- **CPU/CMD fairness:** CPU and CMD both held requesting, no DISP, 6 slots.
  - Expect grants in the order CPU, CMD, CPU, CMD, CPU, CMD.
- **Anti-starvation:** DISP and CPU held continuously, STARVE_LIMIT=3.
  - Expect the grant pattern DISP, DISP, DISP, CPU repeating.
- **Dropped slot:** MEM_REQ spacing of 3 with RD_LAT=2.
  - Expect every second MEM_REQ to be ignored, with exactly one `RAM_CE` per completed access.
- **TG_EN and write:** TG_EN=0 with all REQs high.
  - Expect no `RAM_CE`.
  - Then raise TG_EN with a CPU write of 0xBEEF to 0x00100: expect `RAM_WE`=1, `RAM_WDATA`=0xBEEF, `CPU_ACK` after 3 cycles, and `RDATA` unchanged.
- **Reset mid-access:** assert RESET during WAIT.
  - Expect all outputs to go to 0 immediately and no ACK.
  - After release, the first CPU/CMD tie is granted to CPU.
